// File: rtl/icache_assoc_pkg.sv
// rtl/icache_assoc_pkg.sv - shared types, default geometry and helpers for icache_assoc
// Contents: clog2_min1 width helper, default geometry localparams, icache_addr_t
// (tag/idx/off/byte fields of a fetch address), icache_state_t controller states.
package icache_pkg;

    // Width of an index into n items, never below 1 so 1-entry arrays still get a signal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned SETS_DEF  = 16;
    localparam int unsigned WAYS_DEF  = 2;
    localparam int unsigned WPB_DEF   = 2;
    localparam int unsigned OFF_W_DEF = clog2_min1(WPB_DEF);
    localparam int unsigned IDX_W_DEF = $clog2(SETS_DEF);
    localparam int unsigned TAG_W_DEF = 32 - IDX_W_DEF - OFF_W_DEF - 2;

    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [IDX_W_DEF-1:0] idx;
        logic [OFF_W_DEF-1:0] off;
        logic [1:0]           bsel;
    } icache_addr_t;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} icache_state_t;

endpackage

// File: rtl/icache_assoc_if.sv
// rtl/icache_assoc_if.sv - fetch-side and memory-side bundles of icache_assoc
// icache_dp_if : imemREN, imemaddr, iflush (datapath -> cache); ihit, imemload (cache -> datapath).
// icache_mem_if: iREN, iaddr (cache -> memory); iwait, iload (memory -> cache).
interface icache_dp_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;

    modport master (output imemREN, imemaddr, iflush, input ihit, imemload);
    modport slave  (input imemREN, imemaddr, iflush, output ihit, imemload);
endinterface

interface icache_mem_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (output iREN, iaddr, input iwait, iload);
    modport slave  (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_assoc_lru.sv
// rtl/icache_assoc_lru.sv - per-set LRU age storage and victim selection (icache_lru)
// Ports: clk, rst (sync, active-high); idx set index; access/way mark way as most recent;
// victim = way holding the oldest age in set idx.
module icache_lru
    import icache_pkg::*;
#(
    parameter int unsigned SETS = 16,
    parameter int unsigned WAYS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(SETS)-1:0]      idx,
    input  logic                         access,
    input  logic [clog2_min1(WAYS)-1:0]  way,
    output logic [clog2_min1(WAYS)-1:0]  victim
);
    localparam int unsigned WAY_W = clog2_min1(WAYS);

    generate
        if (WAYS == 1) begin : g_single
            logic unused_in;
            assign unused_in = ^{clk, rst, idx, access, way};
            assign victim    = '0;
        end else begin : g_ages
            // Ages form a permutation of 0..WAYS-1 per set; 0 is most recent.
            logic [WAY_W-1:0] age_q [SETS][WAYS];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++)
                        for (int w = 0; w < WAYS; w++)
                            age_q[s][w] <= WAY_W'(w);
                end else if (access) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == way)
                            age_q[idx][w] <= '0;
                        else if (age_q[idx][w] < age_q[idx][way])
                            age_q[idx][w] <= age_q[idx][w] + 1'b1;
                    end
                end
            end

            always_comb begin
                victim = '0;
                for (int w = 0; w < WAYS; w++)
                    if (age_q[idx][w] == WAY_W'(WAYS - 1))
                        victim = WAY_W'(w);
            end
        end
    endgenerate
endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - N-way set-associative read-only instruction cache with LRU and flush
// Ports: CLK; RST (sync, active-high); dp (icache_dp_if.slave) fetch port with zero-cycle hits;
// mem (icache_mem_if.master) block refill, one word per accepted beat (iREN & !iwait).
// Optional ICACHE_PERF_CNT_EN: adds saturating hit_cnt/miss_cnt outputs.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int unsigned SETS          = 16,
    parameter int unsigned WAYS          = 2,
    parameter int unsigned WORDS_PER_BLK = 2
) (
    input  logic        CLK,
    input  logic        RST,
    icache_dp_if.slave  dp,
    icache_mem_if.master mem
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int unsigned OFF_W  = $clog2(WORDS_PER_BLK);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W - 2;
    localparam int unsigned OFF_W1 = clog2_min1(WORDS_PER_BLK);
    localparam int unsigned WAY_W  = clog2_min1(WAYS);

    icache_state_t     state_q, state_d;
    logic [TAG_W-1:0]  ltag_q, ltag_d;
    logic [IDX_W-1:0]  lidx_q, lidx_d;
    logic [OFF_W1-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  fcnt_q, fcnt_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              flush_pend_q, flush_pend_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [31:0]       data_q  [SETS][WAYS][WORDS_PER_BLK];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W1-1:0] req_off;
    logic              unused_bsel;

    assign req_tag     = dp.imemaddr[31 -: TAG_W];
    assign req_idx     = dp.imemaddr[OFF_W + 2 +: IDX_W];
    // Masking keeps the word offset well-defined even for one-word blocks.
    assign req_off     = OFF_W1'(dp.imemaddr[31:2] & 30'(WORDS_PER_BLK - 1));
    assign unused_bsel = ^dp.imemaddr[1:0];

    logic             hit_any, free_any;
    logic [WAY_W-1:0] hit_way, free_way;

    // Descending scan so the lowest-index match wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                free_any = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    logic [IDX_W-1:0] lru_idx;
    logic             lru_access;
    logic [WAY_W-1:0] lru_way, lru_victim;

    assign lru_idx = (state_q == FILL) ? lidx_q : req_idx;

    icache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .clk    (CLK),
        .rst    (RST),
        .idx    (lru_idx),
        .access (lru_access),
        .way    (lru_way),
        .victim (lru_victim)
    );

    logic fill_acc, fill_last;
    assign fill_acc  = (state_q == FILL) && !mem.iwait;
    assign fill_last = (cnt_q == OFF_W1'(WORDS_PER_BLK - 1));

    always_comb begin
        state_d      = state_q;
        ltag_d       = ltag_q;
        lidx_d       = lidx_q;
        cnt_d        = cnt_q;
        fcnt_d       = fcnt_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        lru_access   = 1'b0;
        lru_way      = hit_way;
        dp.ihit      = 1'b0;
        dp.imemload  = '0;
        mem.iREN     = 1'b0;
        mem.iaddr    = '0;
        case (state_q)
            IDLE: begin
                if (dp.imemREN && hit_any) begin
                    dp.ihit     = 1'b1;
                    dp.imemload = data_q[req_idx][hit_way][req_off];
                    lru_access  = 1'b1;
                end
                if (flush_pend_q || dp.iflush) begin
                    state_d      = FLUSH;
                    flush_pend_d = 1'b0;
                    fcnt_d       = '0;
                end else if (dp.imemREN && !hit_any) begin
                    state_d  = FILL;
                    ltag_d   = req_tag;
                    lidx_d   = req_idx;
                    cnt_d    = '0;
                    victim_d = free_any ? free_way : lru_victim;
                end
            end
            FILL: begin
                mem.iREN  = 1'b1;
                mem.iaddr = (32'({ltag_q, lidx_q}) << (OFF_W + 2)) | (32'(cnt_q) << 2);
                if (dp.iflush)
                    flush_pend_d = 1'b1;
                if (fill_acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (fill_last) begin
                        cnt_d      = '0;
                        state_d    = IDLE;
                        lru_access = 1'b1;
                        lru_way    = victim_q;
                    end
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == IDX_W'(SETS - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            ltag_q       <= '0;
            lidx_q       <= '0;
            cnt_q        <= '0;
            fcnt_q       <= '0;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
            for (int s = 0; s < SETS; s++)
                valid_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            ltag_q       <= ltag_d;
            lidx_q       <= lidx_d;
            cnt_q        <= cnt_d;
            fcnt_q       <= fcnt_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
            if (state_q == FLUSH)
                valid_q[fcnt_q] <= '0;
            else if (fill_acc && fill_last)
                valid_q[lidx_q][victim_q] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed through valid bits.
    always_ff @(posedge CLK) begin
        if (!RST && fill_acc) begin
            data_q[lidx_q][victim_q][cnt_q] <= mem.iload;
            if (fill_last)
                tag_q[lidx_q][victim_q] <= ltag_q;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        miss_start;

    assign miss_start = (state_q == IDLE) && (state_d == FILL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (dp.ihit && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 1'b1;
            if (miss_start && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache with multi-word blocks, LRU replacement and whole-cache flush.
- Successor to the direct-mapped single-word icache. Sits between the datapath fetch port and the memory controller's instruction channel.
- Read-only: no dirty state, no write-back.

Parameters:
- SETS, 16, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; power of 2, 1..4.
- WORDS_PER_BLK, 2, 32-bit words per block; power of 2, 1..8.
- Derived: OFF_W=clog2(WORDS_PER_BLK), IDX_W=clog2(SETS), TAG_W=32-IDX_W-OFF_W-2.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  synchronous reset, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- iflush  in  1  one-cycle pulse; invalidate all lines.
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  fetched instruction.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, bits [1:0]=0.
- iwait  in  1  memory not ready; the word is accepted in the cycle iREN=1 and iwait=0.
- iload  in  32  memory data, valid when iREN=1 and iwait=0.

Behaviour:
Address split:
- imemaddr = {tag[TAG_W], idx[IDX_W], off[OFF_W], 2'b00}.

Reset:
- Applies when RST=1 at a clock edge. Takes priority over every other event, including a fill in progress.
- All valid bits cleared; state=IDLE; fill counter=0; flush pending=0.
- LRU ages in every set set to the way index.
- Outputs from the next cycle: ihit=0, iREN=0, iaddr=0, imemload=0.

States:
- IDLE (lookup):
  - ihit is combinational: ihit = imemREN & (any way in set idx is valid with tag equal to the request tag).
  - On a hit, imemload = that way's data[off] in the same cycle (zero-cycle hit latency) and the LRU is updated at the edge.
  - On imemREN with no hit: latch tag and idx; choose the victim (lowest-index invalid way, else the way with maximum age); go to FILL.
  - With pending flush or iflush=1: go to FLUSH. Flush has priority over a miss arriving in the same cycle.
- FILL:
  - iREN=1; iaddr={ltag, lidx, cnt, 2'b00}, with cnt starting at 0.
  - On each accepted word: write it into victim data[cnt]; cnt++.
  - On the last word (cnt=WORDS_PER_BLK-1 accepted): write tag and valid=1, update LRU for the victim, reset cnt to 0, go to IDLE.
  - ihit=0 throughout. The request is re-looked-up in IDLE and hits the cycle after the fill ends.
  - imemaddr changes during FILL are ignored; the latched fill always completes.
  - iflush during FILL sets flush pending; FILL is not aborted.
- FLUSH:
  - Counter walks set 0..SETS-1, clearing all WAYS valid bits of one set per cycle.
  - Takes exactly SETS cycles, then returns to IDLE.
  - ihit=0 and iREN=0 throughout; iflush received during FLUSH is absorbed.
  - LRU ages are not altered.

LRU:
- Each set holds WAYS ages of clog2(WAYS) bits.
- On an access to way w with age a: every way with age < a increments, and w is set to 0.
- Ages always stay a permutation of 0..WAYS-1.
- WAYS=1: no age storage; the victim is always way 0.

Boundaries:
- imemREN=0 in IDLE: ihit=0 and no state change.
- A hit and a miss never occur in the same cycle.
- iwait held high indefinitely: FILL stalls with iREN held and iaddr stable.
- Fill of the last set (idx=SETS-1) or last tag: no wrap side-effects; word addresses never cross the block.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each IDLE cycle with ihit=1.
  - miss_cnt increments on each IDLE to FILL transition.
  - Both saturate at all-ones, clear on RST, and do not clear on iflush.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg holds:
  - typedef icache_addr_t (packed tag/idx/off/byte fields, parametrised through localparams);
  - enum icache_state_t {IDLE, FILL, FLUSH};
  - function clog2_min1.
- Sub-module icache_lru: per-set age storage, with inputs (idx, access, way) and output victim. Instantiated once. Keeps replacement policy swappable.

Test Plan:
- Reset then read 0x0000_0040 (SETS=16, WAYS=2, WPB=2); memory returns 0xAAAA_0000, 0xAAAA_0001 for words 0x40, 0x44, with iwait=1 for 2 cycles before each word.
  - Expect iaddr sequence 0x40, 0x44.
  - Expect ihit the cycle after the fill, with imemload=0xAAAA_0000.
  - A following read of 0x44 hits in 0 cycles with 0xAAAA_0001.
- Conflict/LRU: fill 0x040 (way0), fill 0x240 (same idx → way1), read 0x040, then miss on 0x440.
  - Expect way1 evicted: 0x240 now misses and 0x040 still hits.
- iflush during FILL of 0x80.
  - Fill completes (2 words accepted), then FLUSH lasts exactly 16 cycles with ihit=0 and iREN=0.
  - Read 0x80 afterwards misses.
- RST asserted mid-FILL after 1 accepted word.
  - Next cycle iREN=0 and ihit=0.
  - Read of the same address re-fills from word 0.
- imemaddr changed from 0x100 to 0x200 during the fill of 0x100.
  - iaddr stays 0x100/0x104.
  - After the fill, the 0x200 lookup misses and a new fill starts.
- With ICACHE_PERF_CNT_EN: 3 misses then 5 hits → hit_cnt=5, miss_cnt=3; iflush leaves both unchanged.
